// File: rtl/rf_wb_arbiter_pkg.sv
// Shared types and constants for the register-file write-back arbiter.
// Holds the write-request record and the round-robin priority encoding.
package rf_wb_arbiter_pkg;

    localparam int RF_ADDR_W = 5;
    localparam int RF_DATA_W = 32;
    localparam logic [RF_ADDR_W-1:0] RF_ZERO_ADDR = '0;

    typedef struct packed {
        logic                 valid;
        logic [RF_ADDR_W-1:0] addr;
        logic [RF_DATA_W-1:0] data;
    } wr_req_t;

    typedef enum logic {
        PRIO_M0 = 1'b0,
        PRIO_M1 = 1'b1
    } prio_t;

    // An accepted request becomes a write only when it does not target r0.
    function automatic wr_req_t wb_entry(input wr_req_t req);
        wr_req_t ent;
        ent.valid = req.valid && (req.addr != RF_ZERO_ADDR);
        ent.addr  = req.addr;
        ent.data  = req.data;
        return ent;
    endfunction

endpackage

// File: rtl/rf_rr_arb2.sv
// Two-way round-robin grant logic with its priority flop.
// Grants are combinational from request valids and the priority state.
module rf_rr_arb2
    import rf_wb_arbiter_pkg::*;
#(
    parameter int RST_PRIO = 0
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    // state   | meaning
    // PRIO_M0 | requester 0 wins when both request
    // PRIO_M1 | requester 1 wins when both request
    localparam prio_t PRIO_RST = (RST_PRIO == 0) ? PRIO_M0 : PRIO_M1;

    prio_t prio_q;
    prio_t prio_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio_q <= PRIO_RST;
        end else begin
            prio_q <= prio_d;
        end
    end

    always_comb begin
        grant  = 2'b00;
        prio_d = prio_q;
        if (!reset) begin
            case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = (prio_q == PRIO_M0) ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
        // Any grant hands priority to the other side; idle cycles keep it.
        if (grant[0]) begin
            prio_d = PRIO_M1;
        end else if (grant[1]) begin
            prio_d = PRIO_M0;
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-back arbiter: two requesters, one registered write port.
// Optional read bypass from the output stage is enabled by RF_WB_BYPASS_EN.
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int RST_PRIO = 0
)
(
    input  logic                 clk,
    input  logic                 reset,

    input  logic                 m0_valid,
    output logic                 m0_ready,
    input  logic [RF_ADDR_W-1:0] m0_addr,
    input  logic [RF_DATA_W-1:0] m0_data,

    input  logic                 m1_valid,
    output logic                 m1_ready,
    input  logic [RF_ADDR_W-1:0] m1_addr,
    input  logic [RF_DATA_W-1:0] m1_data,

    output logic                 rf_we,
    output logic [RF_ADDR_W-1:0] rf_waddr,
    output logic [RF_DATA_W-1:0] rf_wdata,

    input  logic [RF_ADDR_W-1:0] raddr1,
    input  logic [RF_ADDR_W-1:0] raddr2,
    input  logic [RF_DATA_W-1:0] rf_rdata1,
    input  logic [RF_DATA_W-1:0] rf_rdata2,
    output logic [RF_DATA_W-1:0] rdata1,
    output logic [RF_DATA_W-1:0] rdata2
);

    wr_req_t    req0;
    wr_req_t    req1;
    logic [1:0] grant;
    wr_req_t    wb_d;
    wr_req_t    wb_q;

    assign req0 = '{valid: m0_valid, addr: m0_addr, data: m0_data};
    assign req1 = '{valid: m1_valid, addr: m1_addr, data: m1_data};

    rf_rr_arb2 #(
        .RST_PRIO (RST_PRIO)
    ) u_arb (
        .clk   (clk),
        .reset (reset),
        .req   ({m1_valid, m0_valid}),
        .grant (grant)
    );

    assign m0_ready = grant[0];
    assign m1_ready = grant[1];

    always_comb begin
        wb_d = '0;
        if (grant[0]) begin
            wb_d = wb_entry(req0);
        end else if (grant[1]) begin
            wb_d = wb_entry(req1);
        end
    end

    // Reloaded every cycle so an idle cycle drops rf_we.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_q <= '0;
        end else begin
            wb_q <= wb_d;
        end
    end

    assign rf_we    = wb_q.valid;
    assign rf_waddr = wb_q.addr;
    assign rf_wdata = wb_q.data;

`ifdef RF_WB_BYPASS_EN
    logic hit1;
    logic hit2;

    // wb_q.valid already excludes r0, the explicit check keeps the intent local.
    assign hit1   = wb_q.valid && (wb_q.addr == raddr1) && (raddr1 != RF_ZERO_ADDR);
    assign hit2   = wb_q.valid && (wb_q.addr == raddr2) && (raddr2 != RF_ZERO_ADDR);
    assign rdata1 = hit1 ? wb_q.data : rf_rdata1;
    assign rdata2 = hit2 ? wb_q.data : rf_rdata2;
`else
    logic unused_raddr;

    assign unused_raddr = ^{raddr1, raddr2};
    assign rdata1       = rf_rdata1;
    assign rdata2       = rf_rdata2;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios plus random traffic
// compared against a grant-order write model and a shadow register file.
module tb_rf_wb_arbiter;

    localparam int RST_PRIO = 0;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        m0_valid, m1_valid;
    logic        m0_ready, m1_ready;
    logic [4:0]  m0_addr, m1_addr;
    logic [31:0] m0_data, m1_data;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [4:0]  raddr1, raddr2;
    logic [31:0] rf_rdata1, rf_rdata2;
    logic [31:0] rdata1, rdata2;

    rf_wb_arbiter #(.RST_PRIO(RST_PRIO)) dut (
        .clk       (clk),
        .reset     (reset),
        .m0_valid  (m0_valid),
        .m0_ready  (m0_ready),
        .m0_addr   (m0_addr),
        .m0_data   (m0_data),
        .m1_valid  (m1_valid),
        .m1_ready  (m1_ready),
        .m1_addr   (m1_addr),
        .m1_data   (m1_data),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .raddr1    (raddr1),
        .raddr2    (raddr2),
        .rf_rdata1 (rf_rdata1),
        .rf_rdata2 (rf_rdata2),
        .rdata1    (rdata1),
        .rdata2    (rdata2)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail = 0;

    // Reference model: who holds priority, and the write due on the port.
    int          prio_m;
    logic        exp_we;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
    logic [31:0] mdl_rf [32];
    logic [31:0] dut_rf [32];
    int          last_g;
    logic        obs_r0, obs_r1;
    int          grants [$];
    int          wait0, wait1;
    bit          hold0, hold1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                         input logic v1, input logic [4:0] a1, input logic [31:0] d1);
        m0_valid = v0; m0_addr = a0; m0_data = d0;
        m1_valid = v1; m1_addr = a1; m1_data = d1;
    endtask

    function automatic logic [31:0] exp_rdata(input logic [4:0] ra, input logic [31:0] raw);
`ifdef RF_WB_BYPASS_EN
        if (exp_we && exp_addr == ra && ra != 5'd0) return exp_data;
`endif
        return raw;
    endfunction

    // One clock: check at the falling edge, then advance the model on the rising edge.
    task automatic tick();
        int g;
        @(negedge clk);
        g = -1;
        if (m0_valid && m1_valid) g = prio_m;
        else if (m0_valid)        g = 0;
        else if (m1_valid)        g = 1;
        obs_r0 = m0_ready;
        obs_r1 = m1_ready;
        check("m0_ready", {31'd0, m0_ready}, {31'd0, g == 0});
        check("m1_ready", {31'd0, m1_ready}, {31'd0, g == 1});
        check("rf_we", {31'd0, rf_we}, {31'd0, exp_we});
        if (exp_we) begin
            check("rf_waddr", {27'd0, rf_waddr}, {27'd0, exp_addr});
            check("rf_wdata", rf_wdata, exp_data);
        end
        check("rdata1", rdata1, exp_rdata(raddr1, rf_rdata1));
        check("rdata2", rdata2, exp_rdata(raddr2, rf_rdata2));
        if (rf_we === 1'b1) dut_rf[rf_waddr] = rf_wdata;
        last_g = g;
        if (g >= 0) grants.push_back(g);
        @(posedge clk);
        if (g == 0) begin
            exp_we = (m0_addr != 5'd0); exp_addr = m0_addr; exp_data = m0_data; prio_m = 1;
        end else if (g == 1) begin
            exp_we = (m1_addr != 5'd0); exp_addr = m1_addr; exp_data = m1_data; prio_m = 0;
        end else begin
            exp_we = 1'b0;
        end
        if (exp_we) mdl_rf[exp_addr] = exp_data;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #2;
        check("rst_we", {31'd0, rf_we}, 32'd0);
        check("rst_waddr", {27'd0, rf_waddr}, 32'd0);
        check("rst_wdata", rf_wdata, 32'd0);
        check("rst_m0_ready", {31'd0, m0_ready}, 32'd0);
        check("rst_m1_ready", {31'd0, m1_ready}, 32'd0);
        prio_m = RST_PRIO;
        exp_we = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            mdl_rf[i] = 32'd0;
            dut_rf[i] = 32'd0;
        end
        exp_we = 1'b0; exp_addr = 5'd0; exp_data = 32'd0; prio_m = RST_PRIO;
        last_g = -1; wait0 = 0; wait1 = 0; hold0 = 0; hold1 = 0;
        raddr1 = 5'd0; raddr2 = 5'd0; rf_rdata1 = 32'd0; rf_rdata2 = 32'd0;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        #1;
        do_reset();

        // Single write, latency one.
        drive(1'b1, 5'd5, 32'h1234_5678, 1'b0, 5'd0, 32'd0);
        tick();
        check("w5_ready", {31'd0, obs_r0}, 32'd1);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        #1;
        check("w5_we", {31'd0, rf_we}, 32'd1);
        check("w5_data", rf_wdata, 32'h1234_5678);
        tick();

        // Round robin from reset priority.
        do_reset();
        grants.delete();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5'(10 + i), 32'(i), 1'b1, 5'(20 + i), 32'(100 + i));
            tick();
        end
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        tick();
        check("rr_cnt", 32'(grants.size()), 32'd4);
        for (int i = 0; i < 4 && i < grants.size(); i++)
            check("rr_order", 32'(grants[i]), 32'(i % 2));

        // r0 write acknowledged but dropped.
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF_FFFF);
        tick();
        check("r0_ready", {31'd0, obs_r1}, 32'd1);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        #1;
        check("r0_we", {31'd0, rf_we}, 32'd0);
        tick();

        // Same address from both sides: later grant wins.
        do_reset();
        drive(1'b1, 5'd9, 32'hA, 1'b1, 5'd9, 32'hB);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'hB);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        #1;
        check("same_addr_data", rf_wdata, 32'hB);
        tick();
        check("same_addr_rf", dut_rf[9], 32'hB);

        // Bypass from the output stage.
        drive(1'b1, 5'd3, 32'h77, 1'b0, 5'd0, 32'd0);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        raddr1 = 5'd3; rf_rdata1 = 32'd0;
        #1;
`ifdef RF_WB_BYPASS_EN
        check("bypass_hit", rdata1, 32'h77);
`else
        check("bypass_off", rdata1, 32'd0);
`endif
        tick();

        // Reset while a write sits in the output stage.
        drive(1'b1, 5'd7, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0);
        tick();
        drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2);
        #1;
        check("pre_rst_we", {31'd0, rf_we}, 32'd1);
        do_reset();
        drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22);
        tick();
        check("post_rst_prio", {31'd0, obs_r0}, 32'd1);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        tick();

        // Random traffic; a stalled requester keeps valid but changes its payload.
        for (int c = 0; c < 400; c++) begin
            logic v0, v1;
            v0 = hold0 ? 1'b1 : ($urandom_range(0, 9) < 6);
            v1 = hold1 ? 1'b1 : ($urandom_range(0, 9) < 6);
            drive(v0, ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 7)), $urandom(),
                  v1, ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 7)), $urandom());
            raddr1 = 5'($urandom_range(0, 7));
            raddr2 = 5'($urandom_range(0, 7));
            rf_rdata1 = $urandom();
            rf_rdata2 = $urandom();
            tick();
            if (m0_valid) begin
                wait0 = obs_r0 ? 0 : wait0 + 1;
                check("starve_m0", {31'd0, wait0 < 2}, 32'd1);
            end else wait0 = 0;
            if (m1_valid) begin
                wait1 = obs_r1 ? 0 : wait1 + 1;
                check("starve_m1", {31'd0, wait1 < 2}, 32'd1);
            end else wait1 = 0;
            hold0 = m0_valid && (last_g != 0);
            hold1 = m1_valid && (last_g != 1);
        end
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        tick();
        tick();
        for (int i = 0; i < 32; i++)
            check($sformatf("rf_final[%0d]", i), dut_rf[i], mdl_rf[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
